// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pooling stages: data width, output-dimension
// derivation and counter sizing helpers.
package maxpool_pkg;

    localparam int unsigned DATA_W = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

    // A 3x3 window without padding loses one pixel on each border.
    function automatic int unsigned out_dim(input int unsigned n);
        return n - 2;
    endfunction

endpackage

// File: rtl/maxpool_stride_out_if.sv
// Stream bundle between the max9 stage, the stride/output stage and the next layer.
interface maxpool_stride_out_if
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W
) ();

    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  frame_done;
    logic                  overflow;

    modport master (
        output valid_in, data_in, ready_in,
        input  valid_out, data_out, frame_done, overflow
    );

    modport slave (
        input  valid_in, data_in, ready_in,
        output valid_out, data_out, frame_done, overflow
    );

endinterface

// File: rtl/maxpool_out_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a counter.
module maxpool_out_fifo
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  pop_ok;
    logic                  push_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/maxpool_stride_out.sv
// Stride decimation of the stride-1 3x3 max stream, frame tracking and
// buffered valid/ready output towards the next convolution layer.
module maxpool_stride_out
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned HEIGHT     = 5,
    parameter int unsigned STRIDE     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    maxpool_stride_out_if.slave bus
);

    localparam int unsigned OUT_W = out_dim(WIDTH);
    localparam int unsigned OUT_H = out_dim(HEIGHT);
    localparam int unsigned CW    = cnt_bits(OUT_W);
    localparam int unsigned RW    = cnt_bits(OUT_H);
    localparam int unsigned PW    = cnt_bits(STRIDE);

    logic [CW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic [PW-1:0]         col_ph;
    logic [PW-1:0]         row_ph;
    logic                  frame_done;
    logic                  overflow;
    logic                  last_col;
    logic                  last_row;
    logic                  keep;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        last_col = (col_cnt == CW'(OUT_W - 1));
        last_row = (row_cnt == RW'(OUT_H - 1));
        keep     = bus.valid_in && (col_ph == '0) && (row_ph == '0);
        pop      = !empty && bus.ready_in;
        push     = keep && (!full || pop);
        drop     = keep && full && !pop;
    end

    // Phases restart at every row/frame wrap so the grid is anchored to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            col_ph     <= '0;
            row_ph     <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= bus.valid_in && last_col && last_row;
            if (drop) overflow <= 1'b1;
            if (bus.valid_in) begin
                if (last_col) begin
                    col_cnt <= '0;
                    col_ph  <= '0;
                    if (last_row) begin
                        row_cnt <= '0;
                        row_ph  <= '0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                        row_ph  <= (row_ph == PW'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
                    end
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                    col_ph  <= (col_ph == PW'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
                end
            end
        end
    end

    maxpool_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.data_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign bus.valid_out  = !empty;
    assign bus.data_out   = head;
    assign bus.frame_done = frame_done;
    assign bus.overflow   = overflow;

endmodule

// File: doc/maxpool_stride_out.md
# maxpool_stride_out

Downstream stage of the 3x3 max-pooling control/datapath. It consumes the stride-1 stream of 3x3 maxima in raster order, keeps only positions on the pooling stride grid, and buffers the survivors in a small FIFO. The FIFO presents them to the next VGG16 convolution layer with a valid/ready handshake. The stage also tracks frame position, pulses at end of frame, and flags overflow because the upstream pooling stage has no backpressure.

## Interface
- DATA_WIDTH, 16, bit width of one max value
- WIDTH, 5, input feature-map width in pixels; results per row OUT_W = WIDTH-2
- HEIGHT, 5, input feature-map height; result rows OUT_H = HEIGHT-2
- STRIDE, 2, pooling stride (>=1) applied to both rows and columns
- FIFO_DEPTH, 4, output buffer entries (power of two, >=2)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- valid_in  in  1  data_in holds one 3x3 max result (driven by the max9 stage's valid_out)
- data_in  in  DATA_WIDTH  max result
- ready_in  in  1  downstream accepts data_out this cycle
- valid_out  out  1  data_out valid (FIFO not empty)
- data_out  out  DATA_WIDTH  head-of-FIFO value
- frame_done  out  1  one-cycle pulse after the last result of a frame is consumed from the input
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full

## Operation
- col_cnt runs 0..OUT_W-1 and row_cnt runs 0..OUT_H-1. Both advance only on valid_in.
- col_cnt wraps to 0 at OUT_W-1 and increments row_cnt. row_cnt wraps to 0 at OUT_H-1, which ends the frame.
- col_ph and row_ph are phase counters 0..STRIDE-1. They reset to 0 at each row or frame wrap. No modulo operators are used.
- A sample is kept when valid_in=1, col_ph==0 and row_ph==0. WIDTH=5, HEIGHT=5, STRIDE=2 keeps (0,0), (0,2), (2,0), (2,2).
- Push: the sample is kept and the FIFO is not full, or the FIFO is full and a pop occurs in the same cycle.
- Pop: valid_out and ready_in are both 1.
- When push and pop occur together, the occupancy is unchanged and order is preserved.
- A kept sample that cannot be pushed is dropped, and overflow is set to 1. Overflow holds until rst. Counters still advance, so frame alignment is never lost.
- Discarded (non-grid) samples never touch the FIFO.
- frame_done is registered and high for exactly one cycle following the input cycle with row_cnt==OUT_H-1 and col_cnt==OUT_W-1. It is independent of the FIFO drain.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Wrap is natural binary.

## Timing
- Reset values: valid_out=0, data_out=0, frame_done=0, overflow=0. All counters and phases are 0 and the FIFO is empty.
- Latency: a kept sample arriving in cycle N into an empty FIFO gives valid_out=1 with that data in cycle N+1.
- data_out and valid_out are stable while valid_out=1 and ready_in=0.
- Throughput: one push and one pop per cycle.
- rst mid-frame or mid-drain discards FIFO contents and restarts counting at (0,0) on the next valid_in. valid_in during the rst cycle is ignored.
- ready_in while valid_out=0 has no effect.

## Structure
- Shared package maxpool_pkg: a clog2 function, the OUT_W/OUT_H derivation, and the data type width parameter used by the pooling stages.
- One sub-module, maxpool_out_fifo: a synchronous first-word-fall-through FIFO with full/empty, push, and pop. The stride/frame counters live in the top.

## Test plan
- Basic grid: defaults, 9 consecutive valid_in with data 1..9 and ready_in=1. Required: data_out sequence 1, 3, 7, 9; frame_done one pulse the cycle after input 9; overflow=0.
- Gapped input: same data with valid_in toggling every other cycle. Required: identical output sequence, and counters do not advance on idle cycles.
- Backpressure and overflow: FIFO_DEPTH=2, WIDTH=HEIGHT=6, STRIDE=1, ready_in=0, 16 results. Required: first 2 held in order and overflow=1 from the 3rd kept sample. Then raise ready_in: outputs are values 1 and 2 only.
- Full with simultaneous pop: FIFO full, a kept sample and a pop in the same cycle. Required: no drop, overflow stays 0, order intact.
- Reset mid-frame: rst after 5 inputs with 2 entries queued. Required: valid_out=0 the next cycle. A new 9-sample frame with data 11..19 yields 11, 13, 17, 19.
- Multi-frame: two back-to-back frames. Required: two frame_done pulses and 8 outputs in order.
